interrupt_controller: RTL

- Sits directly upstream of top8227 and drives its nonMaskableInterrupt and interruptRequest inputs.
- Synchronises external interrupt sources, latches events, and applies a per-source mask.
- Prioritises pending sources and reports the winning source ID.
- Detects the CPU's vector fetch on the address bus, which acts as the acknowledge and retires the serviced event.

---
 rtl/interrupt_controller.sv | 124 ++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// IRQ/NMI front end for top8227: synchronises, latches, masks and prioritises interrupt sources.
// Pend/NMI outputs change 2 edges after a source is first sampled; acks are vector fetches, no backpressure.
module interrupt_controller #(
   parameter int                 NUM_IRQ    = 8,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK  = {NUM_IRQ{1'b1}},
   parameter logic [15:0]        IRQ_VECTOR = 16'hFFFE,
   parameter logic [15:0]        NMI_VECTOR = 16'hFFFA
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic [NUM_IRQ-1:0] irq_src,
   input  logic               nmi_src,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic [NUM_IRQ-1:0] irq_clear,
   input  logic [7:0]         AddressBusHigh,
   input  logic [7:0]         AddressBusLow,
   output logic               interruptRequest,
   output logic               nonMaskableInterrupt,
   output logic [NUM_IRQ-1:0] irq_pending,
   output logic [3:0]         irq_id,
   output logic               irq_ack,
   output logic               nmi_ack
);
   typedef enum logic [1:0] {N_IDLE, N_ASSERT, N_RELEASE} nmiState_t;

   logic [NUM_IRQ-1:0] irqSync1, irqSync2, irqHist, pend;
   logic [NUM_IRQ-1:0] active, irqRise, ackClear, pendNext;
   logic               nmiSync1, nmiSync2, nmiHist;
   logic               irqPrevMatch, nmiPrevMatch;
   logic               irqMatch, nmiMatch, irqFetch, nmiFetch;
   logic [15:0]        addr;
   logic [3:0]         winner;
   nmiState_t          nmiState;

   assign addr     = {AddressBusHigh, AddressBusLow};
   assign irqMatch = (addr == IRQ_VECTOR);
   assign nmiMatch = (addr == NMI_VECTOR);
   assign nmiFetch = nmiMatch & ~nmiPrevMatch;

   assign active   = pend & irq_mask;
   assign irqFetch = irqMatch & ~irqPrevMatch & (|active);
   assign irqRise  = irqSync2 & ~irqHist;

   assign interruptRequest = |active;
   assign irq_pending      = pend;

   // Lowest index wins.
   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) winner = 4'(i);
      end
   end

   // Isolating the lowest set bit of active gives the winner as a one-hot; only edge bits retire on ack.
   // A fresh edge outranks both ack-clear and irq_clear; level bits simply track the synchronised input.
   always_comb begin
      ackClear = '0;
      if (irqFetch) ackClear = active & ~(active - NUM_IRQ'(1)) & EDGE_MASK;
      pendNext = (EDGE_MASK & ((pend & ~(irq_clear | ackClear)) | irqRise))
               | (~EDGE_MASK & irqSync2);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         irqSync1     <= '0;
         irqSync2     <= '0;
         irqHist      <= '0;
         pend         <= '0;
         irqPrevMatch <= 1'b0;
         irq_ack      <= 1'b0;
         irq_id       <= '0;
      end else begin
         irqSync1     <= irq_src;
         irqSync2     <= irqSync1;
         irqHist      <= irqSync2;
         pend         <= pendNext;
         irqPrevMatch <= irqMatch;
         irq_ack      <= irqFetch;
         if (irqFetch) irq_id <= winner;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         nmiSync1             <= 1'b0;
         nmiSync2             <= 1'b0;
         nmiHist              <= 1'b0;
         nmiPrevMatch         <= 1'b0;
         nmiState             <= N_IDLE;
         nonMaskableInterrupt <= 1'b0;
         nmi_ack              <= 1'b0;
      end else begin
         nmiSync1     <= nmi_src;
         nmiSync2     <= nmiSync1;
         nmiHist      <= nmiSync2;
         nmiPrevMatch <= nmiMatch;
         nmi_ack      <= 1'b0;
         case (nmiState)
            N_IDLE: begin
               if (nmiSync2 & ~nmiHist) begin
                  nmiState             <= N_ASSERT;
                  nonMaskableInterrupt <= 1'b1;
               end
            end
            N_ASSERT: begin
               if (nmiFetch) begin
                  nmiState             <= N_RELEASE;
                  nonMaskableInterrupt <= 1'b0;
                  nmi_ack              <= 1'b1;
               end
            end
            N_RELEASE: begin
               // Hold off until the source drops so a held-high NMI cannot retrigger.
               if (!nmiSync2) nmiState <= N_IDLE;
            end
            default: begin
               nmiState             <= N_IDLE;
               nonMaskableInterrupt <= 1'b0;
            end
         endcase
      end
   end
endmodule
